osc_dac_voices: RTL and testbench
=================================

Name: osc_dac_voices

Overview:
Parametrised successor to the single phase-accumulator plus delta-sigma DAC chain. NUM_VOICES oscillators are time-multiplexed over one shared phase adder and waveform generator. Each voice has its own frequency, duty, waveform mode and enable, written through a register port. The voices are averaged into one DATA_W-bit mix, which feeds an internal delta-sigma modulator of selectable order (1 or 2) that produces the 1-bit pin output.

Parameters:
NUM_VOICES, 4, number of voices; power of two, 1..16
PHASE_W, 24, phase accumulator and frequency word width
DATA_W, 8, waveform, mix and DAC input width
DSM_ORDER, 1, delta-sigma order; legal values 1 or 2 only

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe, one cycle
cfg_voice  in  log2(NUM_VOICES) (min 1)  target voice
cfg_addr  in  2  0=freq, 1=duty, 2=mode {enable, wave[1:0]}, 3=phase load
cfg_wdata  in  PHASE_W  write data; lower bits used for duty/mode
mix_out  out  DATA_W  averaged voice mix, updated once per frame
sample_valid  out  1  one-cycle pulse when mix_out updates
wrap  out  NUM_VOICES  one-cycle pulse per voice when its phase wraps
dac_out  out  1  modulated 1-bit output

Behaviour:
- Reset values: all phases, freqs, duties, modes, accumulator, integrators = 0; mix_out=0, sample_valid=0, wrap=0, dac_out=0; slot counter=0.
- Sequencer: slot counter 0..NUM_VOICES-1, advancing every clk and wrapping. One frame = NUM_VOICES cycles.
- In slot v:
  - Sample s_v is computed from the current phase[v], i.e. before it updates.
  - If enable[v]=1, phase[v] <= phase[v] + freq[v] (mod 2^PHASE_W).
  - If that addition carries out, wrap[v] pulses on the next cycle.
- Waveforms, with p = phase[v][PHASE_W-1 -: DATA_W]:
  - wave 0, square: s = (p < duty) ? all-ones : 0. duty 0 gives 0; duty all-ones gives high for all but one code.
  - wave 1, saw: s = p.
  - wave 2, triangle: s = p[MSB] ? ~{p[DATA_W-2:0],1'b0} : {p[DATA_W-2:0],1'b0}.
  - wave 3: s = 0.
- Disabled voice: s = 0 and its phase is frozen.
- Mixer:
  - acc width is DATA_W + log2(NUM_VOICES).
  - acc accumulates s_v over slots 0..N-2.
  - In slot N-1: mix_out <= (acc + s_{N-1}) >> log2(NUM_VOICES), acc <= 0, sample_valid pulses with the new mix_out.
  - Latency from a voice's slot to mix_out is at most NUM_VOICES cycles.
- Config writes:
  - Take effect the cycle after cfg_we.
  - A write to the voice being processed in the same cycle is seen from that voice's next slot.
  - Exception: a phase load (addr 3) in the same cycle as that voice's update wins over the increment, and no wrap pulse is generated.
- DSM order 1:
  - sigma is DATA_W+1 bits; each clk, sigma <= {1'b0, sigma[DATA_W-1:0]} + mix_out, and dac_out <= carry of that sum.
  - Mean density = mix_out / 2^DATA_W.
- DSM order 2:
  - Signed integrators i1, i2, each DATA_W+4 bits, with saturation; fb = dac_out ? 2^DATA_W : 0.
  - Each clk: i1 <= i1 + mix_out - fb; i2 <= i2 + i1 - fb; dac_out <= (i2_next >= 0).
  - Integrators saturate instead of wrapping.
- DAC runs every clk on the held mix_out; it is not tied to the frame.
- Reset mid-operation clears everything immediately, including config registers, and restarts at slot 0.

Decomposition:
- Shared package osc_pkg holds:
  - wave encodings WAVE_SQUARE/SAW/TRI/OFF
  - cfg_addr constants ADDR_FREQ/DUTY/MODE/PHASE
  - a clog2-based helper for the voice index width
- Sub-module delta_sigma_mod (params DATA_W, DSM_ORDER) contains the order-1/order-2 modulator.
- The sequencer, voice register file and mixer stay in the top module.

Test Plan:
1. NUM_VOICES=4, voice0 square, duty 0x80, freq 0x100000, others disabled -> mix_out alternates 0x3F/0x00, each for 8 frames; wrap[0] every 64 clk; dac_out density about 12.3% ±1% over 4096 cycles.
2. All 4 voices saw, freq 0x010000, enabled, phases loaded 0 -> mix_out equals voice0 saw top byte; mix_out steps once per frame; sample_valid exactly every 4 clk.
3. Voice1 triangle, freq 0x080000 -> p=0x40 gives s=0x80; p=0xC0 gives s=0x7F; mix_out = s>>2.
4. Phase-load voice2 to 0xFFFFF0 in its own slot with freq 0x20 -> phase reads 0xFFFFF0 and no wrap that slot; wrap[2] pulses one frame later.
5. DSM_ORDER=2, static mix_out 0x40 -> dac_out density 25% ±1% over 8192 cycles; mix 0x00 gives no ones after settling; mix 0xFF gives density ≥99%.
6. Assert rst_n low mid-frame with dac_out toggling -> all outputs 0 within the same cycle; after release, first sample_valid occurs at clk 4.

Source files
------------

// File: rtl/osc_pkg.sv
// Shared encodings and helpers for the multi-voice oscillator / DAC block.
package osc_pkg;

  // Waveform select held in mode[1:0]
  localparam logic [1:0] WAVE_SQUARE = 2'd0;
  localparam logic [1:0] WAVE_SAW    = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_OFF    = 2'd3;

  // Register-port address map
  localparam logic [1:0] ADDR_FREQ   = 2'd0;
  localparam logic [1:0] ADDR_DUTY   = 2'd1;
  localparam logic [1:0] ADDR_MODE   = 2'd2;
  localparam logic [1:0] ADDR_PHASE  = 2'd3;

  // Mode word layout: {enable, wave[1:0]}
  localparam int unsigned MODE_W     = 3;

  // Voice index width; a single-voice build still gets a 1-bit index
  function automatic int unsigned voice_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/delta_sigma_mod.sv
// 1-bit delta-sigma modulator, first or second order, driven by a held DATA_W-bit level.
module delta_sigma_mod #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DSM_ORDER = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_dout
);

  if (DSM_ORDER == 2) begin : g_order2
    localparam int unsigned IW = DATA_W + 4;
    // Two guard bits so the raw sums can never wrap before saturation
    localparam int unsigned EW = IW + 2;
    localparam logic signed [EW-1:0] S_MAX  = EW'((1 << (IW - 1)) - 1);
    localparam logic signed [EW-1:0] S_MIN  = ~S_MAX;
    localparam logic signed [EW-1:0] FB_ONE = EW'(1 << DATA_W);

    logic signed [IW-1:0] r_i1;
    logic signed [IW-1:0] r_i2;
    logic                 r_dout;
    logic signed [EW-1:0] w_fb;
    logic signed [EW-1:0] w_i1_sum;
    logic signed [EW-1:0] w_i2_sum;
    logic signed [IW-1:0] w_i1_nxt;
    logic signed [IW-1:0] w_i2_nxt;

    function automatic logic signed [IW-1:0] sat(input logic signed [EW-1:0] x);
      if (x > S_MAX)      return IW'(S_MAX);
      else if (x < S_MIN) return IW'(S_MIN);
      else                return IW'(x);
    endfunction

    assign w_fb     = r_dout ? FB_ONE : '0;
    assign w_i1_sum = EW'(r_i1) + EW'({1'b0, i_din}) - w_fb;
    assign w_i2_sum = EW'(r_i2) + EW'(r_i1) - w_fb;
    assign w_i1_nxt = sat(w_i1_sum);
    assign w_i2_nxt = sat(w_i2_sum);

    // Saturating integrator pair; output is the sign of the new second integrator
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_i1   <= '0;
        r_i2   <= '0;
        r_dout <= 1'b0;
      end else begin
        r_i1   <= w_i1_nxt;
        r_i2   <= w_i2_nxt;
        r_dout <= ~w_i2_nxt[IW-1];
      end
    end

    assign o_dout = r_dout;
  end else begin : g_order1
    // The carry bit of sigma is the output itself, so only the low bits are kept
    logic [DATA_W-1:0] r_sigma;
    logic              r_dout;
    logic [DATA_W:0]   w_sum;

    assign w_sum = {1'b0, r_sigma} + {1'b0, i_din};

    // First-order error-feedback accumulator
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sigma <= '0;
        r_dout  <= 1'b0;
      end else begin
        r_sigma <= w_sum[DATA_W-1:0];
        r_dout  <= w_sum[DATA_W];
      end
    end

    assign o_dout = r_dout;
  end

endmodule

// File: rtl/osc_dac_voices.sv
// Time-multiplexed phase-accumulator voices, averaging mixer and delta-sigma DAC.
module osc_dac_voices
  import osc_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned PHASE_W    = 24,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DSM_ORDER  = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               cfg_we,
  input  logic [voice_idx_w(NUM_VOICES)-1:0] cfg_voice,
  input  logic [1:0]                         cfg_addr,
  input  logic [PHASE_W-1:0]                 cfg_wdata,
  output logic [DATA_W-1:0]                  mix_out,
  output logic                               sample_valid,
  output logic [NUM_VOICES-1:0]              wrap,
  output logic                               dac_out
);

  localparam int unsigned VIDX_W = voice_idx_w(NUM_VOICES);
  localparam int unsigned LOG2N  = $clog2(NUM_VOICES);
  localparam int unsigned ACC_W  = DATA_W + LOG2N;
  localparam logic [VIDX_W-1:0] LAST_SLOT = VIDX_W'(NUM_VOICES - 1);

  logic [PHASE_W-1:0]    r_phase [NUM_VOICES];
  logic [PHASE_W-1:0]    r_freq  [NUM_VOICES];
  logic [DATA_W-1:0]     r_duty  [NUM_VOICES];
  logic [MODE_W-1:0]     r_mode  [NUM_VOICES];
  logic [VIDX_W-1:0]     r_slot;
  logic [ACC_W-1:0]      r_acc;
  logic [DATA_W-1:0]     r_mix;
  logic                  r_valid;
  logic [NUM_VOICES-1:0] r_wrap;

  logic [PHASE_W-1:0]    w_cur_phase;
  logic [PHASE_W:0]      w_phase_sum;
  logic                  w_cur_en;
  logic [1:0]            w_cur_wave;
  logic [DATA_W-1:0]     w_cur_duty;
  logic [DATA_W-1:0]     w_p;
  logic [DATA_W-1:0]     w_tri;
  logic [DATA_W-1:0]     w_sample;
  logic [ACC_W-1:0]      w_acc_sum;
  logic                  w_load;
  logic                  w_load_cur;
  logic                  w_last;
  logic                  w_dac;

  assign w_cur_phase = r_phase[r_slot];
  assign w_cur_en    = r_mode[r_slot][2];
  assign w_cur_wave  = r_mode[r_slot][1:0];
  assign w_cur_duty  = r_duty[r_slot];
  assign w_phase_sum = {1'b0, w_cur_phase} + {1'b0, r_freq[r_slot]};
  assign w_p         = w_cur_phase[PHASE_W-1 -: DATA_W];
  assign w_tri       = {w_p[DATA_W-2:0], 1'b0};
  assign w_load      = cfg_we && (cfg_addr == ADDR_PHASE);
  assign w_load_cur  = w_load && (cfg_voice == r_slot);
  assign w_last      = (r_slot == LAST_SLOT);
  assign w_acc_sum   = r_acc + ACC_W'(w_sample);

  // Waveform of the voice in the current slot, taken from its pre-update phase
  always_comb begin
    w_sample = '0;
    if (w_cur_en) begin
      case (w_cur_wave)
        WAVE_SQUARE: w_sample = (w_p < w_cur_duty) ? '1 : '0;
        WAVE_SAW:    w_sample = w_p;
        WAVE_TRI:    w_sample = w_p[DATA_W-1] ? ~w_tri : w_tri;
        default:     w_sample = '0;
      endcase
    end
  end

  // Slot sequencer, one voice per clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_slot <= '0;
    else if (w_last) r_slot <= '0;
    else             r_slot <= r_slot + VIDX_W'(1);
  end

  // Phase accumulators; a phase load issued later in the block overrides the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) r_phase[i] <= '0;
    end else begin
      if (w_cur_en) r_phase[r_slot] <= w_phase_sum[PHASE_W-1:0];
      if (w_load)   r_phase[cfg_voice] <= cfg_wdata;
    end
  end

  // Per-voice frequency, duty and mode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        r_freq[i] <= '0;
        r_duty[i] <= '0;
        r_mode[i] <= '0;
      end
    end else if (cfg_we) begin
      case (cfg_addr)
        ADDR_FREQ: r_freq[cfg_voice] <= cfg_wdata;
        ADDR_DUTY: r_duty[cfg_voice] <= cfg_wdata[DATA_W-1:0];
        ADDR_MODE: r_mode[cfg_voice] <= cfg_wdata[MODE_W-1:0];
        default:   ;
      endcase
    end
  end

  // Wrap pulse for the voice whose increment carried, unless a load replaced it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wrap <= '0;
    else if (w_cur_en && w_phase_sum[PHASE_W] && !w_load_cur)
      r_wrap <= NUM_VOICES'(1) << r_slot;
    else
      r_wrap <= '0;
  end

  // Frame accumulator; the last slot folds in its sample and publishes the average
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_mix   <= '0;
      r_valid <= 1'b0;
    end else if (w_last) begin
      r_acc   <= '0;
      r_mix   <= DATA_W'(w_acc_sum >> LOG2N);
      r_valid <= 1'b1;
    end else begin
      r_acc   <= w_acc_sum;
      r_valid <= 1'b0;
    end
  end

  delta_sigma_mod #(
    .DATA_W    (DATA_W),
    .DSM_ORDER (DSM_ORDER)
  ) u_dsm (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_din  (r_mix),
    .o_dout (w_dac)
  );

  assign mix_out      = r_mix;
  assign sample_valid = r_valid;
  assign wrap         = r_wrap;
  assign dac_out      = w_dac;

endmodule

// File: tb/tb_osc_dac_voices.sv
// Bench for osc_dac_voices: order-1 and order-2 builds checked against a behavioural model.
module tb_osc_dac_voices;

  localparam int unsigned NV = 4;
  localparam int unsigned PW = 24;
  localparam int unsigned DW = 8;
  localparam int unsigned VW = 2;
  localparam int unsigned PMOD = 1 << PW;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          cfg_we    = 1'b0;
  logic [VW-1:0] cfg_voice = '0;
  logic [1:0]    cfg_addr  = '0;
  logic [PW-1:0] cfg_wdata = '0;

  logic [DW-1:0] mix1, mix2;
  logic          valid1, valid2;
  logic [NV-1:0] wrap1, wrap2;
  logic          dac1, dac2;

  osc_dac_voices #(.NUM_VOICES(NV), .PHASE_W(PW), .DATA_W(DW), .DSM_ORDER(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .mix_out(mix1), .sample_valid(valid1), .wrap(wrap1), .dac_out(dac1));

  osc_dac_voices #(.NUM_VOICES(NV), .PHASE_W(PW), .DATA_W(DW), .DSM_ORDER(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .mix_out(mix2), .sample_valid(valid2), .wrap(wrap2), .dac_out(dac2));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int unsigned m_phase [NV];
  int unsigned m_freq  [NV];
  int unsigned m_duty  [NV];
  int unsigned m_mode  [NV];
  int unsigned m_slot, m_acc, m_mix, m_valid, m_wrap, m_sig, m_dac1, m_dac2;
  int          m_i1, m_i2;

  function automatic int unsigned wave(input int unsigned ph, input int unsigned duty,
                                       input int unsigned mode);
    int unsigned p;
    p = ph >> (PW - DW);
    if (mode < 4) return 0;
    case (mode % 4)
      0: return (p < duty) ? 255 : 0;
      1: return p;
      2: return (p >= 128) ? 255 - (p % 128) * 2 : (p % 128) * 2;
      default: return 0;
    endcase
  endfunction

  function automatic int clamp(input int x);
    if (x > 2047) return 2047;
    if (x < -2048) return -2048;
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_phase[i] = 0; m_freq[i] = 0; m_duty[i] = 0; m_mode[i] = 0;
    end
    m_slot = 0; m_acc = 0; m_mix = 0; m_valid = 0; m_wrap = 0;
    m_sig = 0; m_dac1 = 0; m_dac2 = 0; m_i1 = 0; m_i2 = 0;
  endtask

  task automatic model_step();
    int unsigned v, s, np, nwrap, sum1, cv;
    int fb, i1n, i2n;
    v = m_slot;
    s = wave(m_phase[v], m_duty[v], m_mode[v]);
    nwrap = 0;
    if (m_mode[v] >= 4) begin
      np = m_phase[v] + m_freq[v];
      if (np >= PMOD) begin
        nwrap = 1 << v;
        np = np - PMOD;
      end
      m_phase[v] = np;
    end
    if (cfg_we) begin
      cv = cfg_voice;
      case (cfg_addr)
        2'd0: m_freq[cv] = cfg_wdata;
        2'd1: m_duty[cv] = cfg_wdata % 256;
        2'd2: m_mode[cv] = cfg_wdata % 8;
        default: begin
          m_phase[cv] = cfg_wdata;
          if (cv == v) nwrap = 0;
        end
      endcase
    end
    // both modulators see the mix level held before this edge
    sum1   = m_sig + m_mix;
    m_dac1 = sum1 / 256;
    m_sig  = sum1 % 256;
    fb     = (m_dac2 != 0) ? 256 : 0;
    i1n    = clamp(m_i1 + int'(m_mix) - fb);
    i2n    = clamp(m_i2 + m_i1 - fb);
    m_i1   = i1n;
    m_i2   = i2n;
    m_dac2 = (i2n >= 0) ? 1 : 0;
    if (v == NV - 1) begin
      m_mix = (m_acc + s) / NV;
      m_acc = 0;
      m_valid = 1;
    end else begin
      m_acc = m_acc + s;
      m_valid = 0;
    end
    m_wrap = nwrap;
    m_slot = (v + 1) % NV;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
    chk("mix1", 32'(mix1), m_mix);
    chk("valid1", 32'(valid1), m_valid);
    chk("wrap1", 32'(wrap1), m_wrap);
    chk("dac1", 32'(dac1), m_dac1);
    chk("mix2", 32'(mix2), m_mix);
    chk("wrap2", 32'(wrap2), m_wrap);
    chk("dac2", 32'(dac2), m_dac2);
  endtask

  task automatic cfg_write(input int unsigned v, input int unsigned a, input int unsigned d);
    cfg_we    = 1'b1;
    cfg_voice = VW'(v);
    cfg_addr  = 2'(a);
    cfg_wdata = PW'(d);
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic wait_slot(input int unsigned v);
    for (int k = 0; k < NV && m_slot != v; k++) tick();
  endtask

  task automatic load_in_slot(input int unsigned v, input int unsigned d);
    wait_slot(v);
    cfg_write(v, 3, d);
  endtask

  task automatic wait_valid();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!valid1 && k < 16);
    if (!valid1) chk("valid_timeout", 32'(0), 32'(1));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int unsigned ones, pm, hi, lo, wraps, run, bad_runs, runs_seen, last_mix, n;
    logic ok;

    model_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mix", 32'(mix1), 32'(0));
    chk("rst_valid", 32'(valid1), 32'(0));
    chk("rst_wrap", 32'(wrap1), 32'(0));
    chk("rst_dac", 32'(dac1), 32'(0));
    rst_n = 1'b1;

    // 1: single square voice at half duty
    cfg_write(0, 0, 32'h100000);
    cfg_write(0, 1, 32'h80);
    cfg_write(0, 2, 4);
    repeat (16) tick();
    hi = 0; lo = 0; wraps = 0; ones = 0; run = 0; bad_runs = 0; runs_seen = 0;
    last_mix = mix1;
    for (int c = 0; c < 4096; c++) begin
      tick();
      ones += dac1;
      if (wrap1[0]) wraps++;
      if (valid1) begin
        if (mix1 == 8'h3F) hi++;
        if (mix1 == 8'h00) lo++;
        if (mix1 != last_mix) begin
          if (runs_seen > 0 && run != 8) bad_runs++;
          runs_seen++;
          run = 0;
        end
        run++;
        last_mix = mix1;
      end
    end
    chk("t1_hi_frames", hi, 512);
    chk("t1_lo_frames", lo, 512);
    chk("t1_wraps", wraps, 64);
    chk("t1_bad_runs", bad_runs, 0);
    pm = ones * 1000 / 4096;
    ok = (pm >= 113 && pm <= 133);
    chk("t1_density_12pct", 32'(ok), 32'(1));

    // 2: four synchronised saws, loads land in each voice's own slot
    for (int unsigned v = 0; v < NV; v++) begin
      cfg_write(v, 0, 32'h010000);
      cfg_write(v, 2, 5);
    end
    for (int unsigned v = 0; v < NV; v++) load_in_slot(v, 0);
    for (int unsigned k = 0; k < 40; k++) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        chk("t2_no_valid", 32'(valid1), 32'(0));
      end
      tick();
      chk("t2_valid", 32'(valid1), 32'(1));
      chk("t2_mix_step", 32'(mix1), k);
    end

    // 3: lone triangle voice
    cfg_write(0, 2, 0);
    cfg_write(2, 2, 0);
    cfg_write(3, 2, 0);
    cfg_write(1, 0, 32'h080000);
    cfg_write(1, 2, 6);
    load_in_slot(1, 32'h400000);
    wait_valid();
    wait_valid();
    chk("t3_tri_rise", 32'(mix1), 32'h20);
    load_in_slot(1, 32'hC00000);
    wait_valid();
    wait_valid();
    chk("t3_tri_fall", 32'(mix1), 32'h1F);

    // 4: own-slot phase load suppresses that slot's wrap
    cfg_write(2, 0, 32'h20);
    cfg_write(2, 2, 5);
    load_in_slot(2, 32'hFFFFF0);
    tick();
    chk("t4_no_wrap", 32'(wrap1[2]), 32'(0));
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("t4_wrap_gap", 32'(wrap1[2]), j == 2 ? 32'(1) : 32'(0));
    end

    // 5: second-order modulator on static levels
    for (int unsigned v = 0; v < NV; v++) cfg_write(v, 2, 0);
    for (int unsigned v = 0; v < 2; v++) begin
      cfg_write(v, 0, 0);
      cfg_write(v, 3, 32'h800000);
      cfg_write(v, 2, 5);
    end
    repeat (512) tick();
    chk("t5_mix_40", 32'(mix2), 32'h40);
    ones = 0;
    repeat (8192) begin tick(); ones += dac2; end
    pm = ones * 1000 / 8192;
    ok = (pm >= 240 && pm <= 260);
    chk("t5_density_25pct", 32'(ok), 32'(1));

    cfg_write(0, 2, 0);
    cfg_write(1, 2, 0);
    repeat (512) tick();
    ones = 0;
    repeat (1024) begin tick(); ones += dac2; end
    chk("t5_zero_ones", ones, 0);

    for (int unsigned v = 0; v < NV; v++) begin
      cfg_write(v, 0, 0);
      cfg_write(v, 1, 255);
      cfg_write(v, 3, 0);
      cfg_write(v, 2, 4);
    end
    repeat (512) tick();
    chk("t5_mix_ff", 32'(mix2), 32'hFF);
    ones = 0;
    repeat (8192) begin tick(); ones += dac2; end
    pm = ones * 1000 / 8192;
    ok = (pm >= 990);
    chk("t5_density_full", 32'(ok), 32'(1));

    // 6: asynchronous reset mid-frame while the modulators run
    cfg_write(0, 2, 0);
    repeat (20) tick();
    wait_slot(2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_mix", 32'(mix1), 32'(0));
    chk("t6_valid", 32'(valid1), 32'(0));
    chk("t6_wrap", 32'(wrap1), 32'(0));
    chk("t6_dac1", 32'(dac1), 32'(0));
    chk("t6_dac2", 32'(dac2), 32'(0));
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid1 && n < 16);
    chk("t6_first_valid_clk", n, 4);

    // random register traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) begin
        cfg_we    = 1'b1;
        cfg_voice = VW'($urandom_range(NV - 1));
        cfg_addr  = 2'($urandom_range(3));
        case (cfg_addr)
          2'd2:    cfg_wdata = PW'($urandom_range(7));
          2'd1:    cfg_wdata = PW'($urandom_range(255));
          default: cfg_wdata = PW'($urandom);
        endcase
      end else begin
        cfg_we = 1'b0;
      end
      tick();
    end
    cfg_we = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
